// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: function codes, FSM states,
// 1-bit slice op encodings and the func -> slice-control decode.
package alu_ctrl_pkg;

  localparam logic [2:0] FUNC_AND = 3'b000;
  localparam logic [2:0] FUNC_OR  = 3'b001;
  localparam logic [2:0] FUNC_ADD = 3'b010;
  localparam logic [2:0] FUNC_SUB = 3'b110;
  localparam logic [2:0] FUNC_NOR = 3'b100;
  localparam logic [2:0] FUNC_SLT = 3'b111;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_SUM = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic       ainvert;
    logic       bnegate;
    logic [2:0] op;
  } ctrl_t;

  function automatic ctrl_t decode_func(input logic [2:0] f);
    ctrl_t c;
    c = '{ainvert: 1'b0, bnegate: 1'b0, op: OP_AND};
    case (f)
      FUNC_OR:            c.op = OP_OR;
      FUNC_ADD:           c.op = OP_SUM;
      FUNC_SUB, FUNC_SLT: begin c.bnegate = 1'b1; c.op = OP_SUM; end
      FUNC_NOR:           begin c.ainvert = 1'b1; c.bnegate = 1'b1; end
      default:            c.op = OP_AND;
    endcase
    return c;
  endfunction

  function automatic logic is_supported(input logic [2:0] f);
    return (f == FUNC_AND) || (f == FUNC_OR) || (f == FUNC_ADD) ||
           (f == FUNC_SUB) || (f == FUNC_NOR) || (f == FUNC_SLT);
  endfunction

endpackage

// File: rtl/alu_1bit.sv
// One-bit ALU slice: optional operand inversion, AND/OR/full-add selected by op.
// Purely combinational; cout is the full-adder carry of the (possibly inverted) inputs.
module alu_1bit
  import alu_ctrl_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       ainvert,
  input  logic       bnegate,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       result,
  output logic       cout
);

  logic aa;
  logic bb;

  assign aa   = a ^ ainvert;
  assign bb   = b ^ bnegate;
  assign cout = (aa & bb) | (aa & cin) | (bb & cin);

  always_comb begin
    result = 1'b0;
    case (op)
      OP_AND:  result = aa & bb;
      OP_OR:   result = aa | bb;
      OP_SUM:  result = aa ^ bb ^ cin;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one bit per clock through a single alu_1bit, LSB first.
// Latency WIDTH+1 cycles from accepted start to done; start is ignored while busy.
module alu_serial_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] r_sr;
  logic [2:0]       func_q;
  logic [CW-1:0]    cnt;
  logic             carry;

  ctrl_t            ctl;
  logic             s_res, s_cout;
  logic             last;
  logic [WIDTH-1:0] r_shift;
  logic             ovf_fin;
  logic [WIDTH-1:0] res_nxt;
  logic             c_nxt, v_nxt;

  assign ctl = decode_func(func_q);

  // Carry register is preloaded with bnegate, so it doubles as cin on the first step.
  alu_1bit u_slice (
    .a       (a_sr[0]),
    .b       (b_sr[0]),
    .ainvert (ctl.ainvert),
    .bnegate (ctl.bnegate),
    .cin     (carry),
    .op      (ctl.op),
    .result  (s_res),
    .cout    (s_cout)
  );

  assign last    = (state == RUN) && (cnt == CW'(WIDTH - 1));
  assign r_shift = {s_res, r_sr};
  assign ovf_fin = carry ^ s_cout;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Final result and flags, evaluated during the last RUN step.
  always_comb begin
    res_nxt = '0;
    c_nxt   = 1'b0;
    v_nxt   = 1'b0;
    case (func_q)
      FUNC_ADD, FUNC_SUB: begin
        res_nxt = r_shift;
        c_nxt   = s_cout;
        v_nxt   = ovf_fin;
      end
      FUNC_SLT: res_nxt = {{(WIDTH-1){1'b0}}, s_res ^ ovf_fin};
      default:  if (is_supported(func_q)) res_nxt = r_shift;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr      <= '0;
      b_sr      <= '0;
      r_sr      <= '0;
      func_q    <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr   <= a;
          b_sr   <= b;
          func_q <= func;
          cnt    <= '0;
          carry  <= decode_func(func).bnegate;
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          r_sr  <= r_shift[WIDTH-1:1];
          carry <= s_cout;
          if (last) begin
            result    <= res_nxt;
            zero      <= (res_nxt == '0);
            carry_out <= c_nxt;
            overflow  <= v_nxt;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl at WIDTH=8: expected results queued at issue,
// popped and compared on each done pulse.
module tb_alu_serial_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   func;
  logic [W-1:0] a, b;
  logic         busy, done, zero, carry_out, overflow;
  logic [W-1:0] result;

  int   n_vec = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .func      (func),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .zero      (zero),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [W:0] s;
    e.r = '0; e.c = 1'b0; e.v = 1'b0;
    case (f)
      3'b000: e.r = x & y;
      3'b001: e.r = x | y;
      3'b100: e.r = ~(x | y);
      3'b010: begin
        s = {1'b0, x} + {1'b0, y};
        e.r = s[W-1:0]; e.c = s[W];
        e.v = (x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]);
      end
      3'b110: begin
        s = {1'b0, x} + {1'b0, ~y} + 1'b1;
        e.r = s[W-1:0]; e.c = s[W];
        e.v = (x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]);
      end
      3'b111: e.r = ($signed(x) < $signed(y)) ? 1 : 0;
      default: e.r = '0;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("sb_empty_on_done", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result",    result,    e.r);
        chk("zero",      zero,      e.z);
        chk("carry_out", carry_out, e.c);
        chk("overflow",  overflow,  e.v);
      end
    end
  end

  // Issue one operation; poke>0 pulses a second (ignored) start in that cycle.
  task automatic run_op(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int poke);
    bit found = 0;
    int d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; func = f; a = x; b = y;
    sb.push_back(model(f, x, y));
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      if (k == 1) chk("busy_c1", busy, 1);
      if (poke > 0 && k == poke) begin start = 1'b1; func = 3'b010; a = '1; b = '1; end
      if (poke > 0 && k == poke + 1) start = 1'b0;
      if (done && !found) begin
        found = 1;
        chk("done_cycle", k, W + 1);
      end
      if (k == W + 1) chk("busy_at_done", busy, 1);
      if (k == W + 2) chk("busy_after", busy, 0);
    end
    if (!found) chk("done_timeout", 0, 1);
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  initial begin
    int d_saved;
    reset = 1'b1; start = 1'b0; func = '0; a = '0; b = '0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {zero, carry_out, overflow}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op(3'b010, 8'h7F, 8'h01, 0);
    run_op(3'b110, 8'h05, 8'h05, 0);
    run_op(3'b110, 8'h80, 8'h01, 0);
    run_op(3'b111, 8'hFE, 8'h01, 0);
    run_op(3'b111, 8'h01, 8'hFE, 0);
    run_op(3'b000, 8'hCC, 8'hAA, 0);
    run_op(3'b001, 8'hCC, 8'hAA, 0);
    run_op(3'b100, 8'hCC, 8'hAA, 0);
    run_op(3'b010, 8'h10, 8'h20, 3);

    // Reset in the middle of an ADD: no done, outputs cleared at once.
    d_saved = done_cnt;
    @(negedge clk);
    start = 1'b1; func = 3'b010; a = 8'h33; b = 8'h44;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    chk("midrst_flags", {zero, carry_out, overflow}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (W + 4) @(negedge clk);
    chk("no_done_after_rst", done_cnt, d_saved);

    run_op(3'b010, 8'hFF, 8'h01, 0);
    run_op(3'b011, 8'h5A, 8'h3C, 0);
    run_op(3'b110, 8'h3C, 8'h5A, 0);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
